// File: rtl/aqp_ovl_console.sv
// Overlay console: turns a byte stream into text-RAM cell writes on the 40x25 grid,
// tracking cursor and attribute and performing hardware row/screen clears.
module aqp_ovl_console #(
    parameter int unsigned COLS       = 40,
    parameter int unsigned ROWS       = 25,
    parameter logic [7:0]  ATTR_RESET = 8'h0F,
    parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [9:0]  ovl_text_addr,
    output logic [15:0] ovl_text_wrdata,
    output logic        ovl_text_wr,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic [7:0]  attr,
    output logic        busy
);

    localparam int unsigned AW = 10;
    localparam int unsigned CW = 6;
    localparam int unsigned RW = 5;

    typedef enum logic [1:0] {IDLE, ESC, CLR_ROW, CLR_ALL} state_t;

    state_t          state_q, state_nxt;
    logic [AW-1:0]   cnt_q, cnt_nxt;
    logic [AW-1:0]   row_base, base_nxt;
    logic [CW-1:0]   col_nxt;
    logic [RW-1:0]   row_nxt;
    logic [7:0]      attr_nxt;
    logic            wr_nxt;
    logic [AW-1:0]   addr_nxt;
    logic [15:0]     data_nxt;
    logic            ready_nxt;
    logic            busy_nxt;
    logic            accept;
    logic            do_lf;

    assign accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= CLR_ALL;
        else          state_q <= state_nxt;
    end

    // Next-state, cursor, attribute and write decisions
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        base_nxt  = row_base;
        col_nxt   = cursor_col;
        row_nxt   = cursor_row;
        attr_nxt  = attr;
        wr_nxt    = 1'b0;
        addr_nxt  = ovl_text_addr;
        data_nxt  = ovl_text_wrdata;
        do_lf     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_data >= 8'h20) begin
                        wr_nxt   = 1'b1;
                        addr_nxt = row_base + AW'(cursor_col);
                        data_nxt = {attr, in_data};
                        if (cursor_col == CW'(COLS - 1)) begin
                            col_nxt = '0;
                            do_lf   = 1'b1;
                        end else begin
                            col_nxt = cursor_col + CW'(1);
                        end
                    end else begin
                        case (in_data)
                            8'h0D: col_nxt = '0;
                            8'h0A: do_lf = 1'b1;
                            8'h08: if (cursor_col != '0) col_nxt = cursor_col - CW'(1);
                            8'h0C: begin
                                col_nxt   = '0;
                                row_nxt   = '0;
                                base_nxt  = '0;
                                cnt_nxt   = '0;
                                state_nxt = CLR_ALL;
                            end
                            8'h1B: state_nxt = ESC;
                            default: ;
                        endcase
                    end
                end
            end
            ESC: begin
                if (accept) begin
                    attr_nxt  = in_data;
                    state_nxt = IDLE;
                end
            end
            CLR_ROW: begin
                wr_nxt   = 1'b1;
                addr_nxt = row_base + cnt_q;
                data_nxt = {attr, FILL_CHAR};
                cnt_nxt  = cnt_q + AW'(1);
                if (cnt_q == AW'(COLS - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            CLR_ALL: begin
                wr_nxt   = 1'b1;
                addr_nxt = cnt_q;
                data_nxt = {attr, FILL_CHAR};
                cnt_nxt  = cnt_q + AW'(1);
                if (cnt_q == {AW{1'b1}}) state_nxt = IDLE;
            end
        endcase

        // Line feed: advance (or wrap) the row, then clear the new row
        if (do_lf) begin
            if (cursor_row == RW'(ROWS - 1)) begin
                row_nxt  = '0;
                base_nxt = '0;
            end else begin
                row_nxt  = cursor_row + RW'(1);
                base_nxt = row_base + AW'(COLS);
            end
            cnt_nxt   = '0;
            state_nxt = CLR_ROW;
        end

        ready_nxt = (state_nxt == IDLE) || (state_nxt == ESC);
        busy_nxt  = (state_nxt == CLR_ROW) || (state_nxt == CLR_ALL);
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q           <= '0;
            row_base        <= '0;
            cursor_col      <= '0;
            cursor_row      <= '0;
            attr            <= ATTR_RESET;
            ovl_text_wr     <= 1'b0;
            ovl_text_addr   <= '0;
            ovl_text_wrdata <= '0;
            in_ready        <= 1'b0;
            busy            <= 1'b1;
        end else begin
            cnt_q           <= cnt_nxt;
            row_base        <= base_nxt;
            cursor_col      <= col_nxt;
            cursor_row      <= row_nxt;
            attr            <= attr_nxt;
            ovl_text_wr     <= wr_nxt;
            ovl_text_addr   <= addr_nxt;
            ovl_text_wrdata <= data_nxt;
            in_ready        <= ready_nxt;
            busy            <= busy_nxt;
        end
    end

endmodule
